// File: rtl/uart_tx_byte.sv
// UART byte transmitter: 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// Latency: tx drops to the start bit in the cycle after the accept edge; a frame lasts (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
// Backpressure: in_ready is high only in IDLE; bytes offered while a frame is in progress are not taken and nothing is buffered.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;      // cycles within the current serial bit
    logic [2:0]       bit_cnt, bit_nxt;  // data bit index, reused to count stop bits
    logic [7:0]       shreg, shreg_nxt;  // captured byte, shifted right as bits go out
    logic             par, par_nxt;      // even-parity bit computed once at capture
    logic             tx_nxt;
    logic             done_nxt;
    logic             bit_end;

    // Status decodes straight off the state register, so in_ready never depends on in_valid.
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign bit_end  = (cnt == CNT_LAST);

    // State and datapath registers; reset aborts any frame and forces the line idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_cnt    <= bit_nxt;
            shreg      <= shreg_nxt;
            par        <= par_nxt;
            tx         <= tx_nxt;
            frame_done <= done_nxt;
        end
    end

    // Next-state and next-output logic; tx is computed one cycle ahead so the line is a clean flop.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        par_nxt   = par;
        tx_nxt    = tx;
        done_nxt  = 1'b0;

        if (state != IDLE) begin
            cnt_nxt = bit_end ? '0 : cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (in_valid) begin
                    state_nxt = START;
                    shreg_nxt = in_data;
                    par_nxt   = ^in_data;
                    tx_nxt    = 1'b0;
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    tx_nxt    = shreg[0];
                    bit_nxt   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == 3'd7) begin
                        bit_nxt = '0;
                        if (PARITY_EN) begin
                            state_nxt = PARITY;
                            tx_nxt    = par;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        bit_nxt   = bit_cnt + 3'd1;
                        shreg_nxt = {1'b0, shreg[7:1]};
                        tx_nxt    = shreg[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                    bit_nxt   = '0;
                end
            end
            STOP: begin
                tx_nxt = 1'b1;
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        state_nxt = IDLE;
                        bit_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/uart_tx_byte.md
Name: uart_tx_byte

Overview:
Serial transmitter stage that consumes the 8-bit `out_data` stream from the free-running counter and emits it as asynchronous UART frames on a single line. It sits directly downstream of the counter. It accepts one byte per valid/ready handshake and holds the byte internally for the whole frame. Frames are 8N1 or 8E1/8E2, with the bit period set in clock cycles.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit; legal range ≥ 2.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.
PARITY_EN, 0, 1 inserts an even-parity bit after data bit 7.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
in_data  input  8  byte to transmit (counter `out_data`)
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  block can accept a byte this cycle
tx  output  1  serial line, idle high, registered
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset asserted (reset=0): asynchronous clear, effective immediately.
  - state=IDLE, tx=1, in_ready=1, busy=0, frame_done=0.
  - Shift register, bit counter and cycle counter = 0.
- Reset mid-frame: frame aborted, tx returns to 1 immediately, captured byte discarded.
- After reset is released, normal operation resumes from IDLE.
- States: IDLE, START, DATA, PARITY, STOP.
- Decoded outputs:
  - in_ready = (state==IDLE), with no combinational path from in_valid.
  - busy = (state!=IDLE).
- Handshake:
  - A transfer occurs on a rising edge with in_valid=1 and in_ready=1.
  - At that edge: in_data is captured, state→START, tx→0, cycle counter cleared.
  - in_data and in_valid are ignored while busy; later changes do not affect the frame in progress.
- Bit timing (C = CLKS_PER_BIT): every serial bit holds tx stable for exactly C cycles; the cycle counter runs 0..C-1.
- START: tx=0 for C cycles, then state→DATA and tx→bit0.
- DATA: 8 bits LSB first, each C cycles. After bit7:
  - PARITY_EN=1: state→PARITY.
  - PARITY_EN=0: state→STOP.
- PARITY: tx = XOR of the 8 data bits (even parity overall), held C cycles, then state→STOP.
- STOP: tx=1 for STOP_BITS×C cycles, then state→IDLE. frame_done=1 for exactly that one cycle after the IDLE transition.
- Frame length from accept edge to return to IDLE: (1+8+PARITY_EN+STOP_BITS)×C cycles.
- IDLE lasts at least one cycle, so the minimum accept-to-accept spacing is that frame length + 1.
  - The line therefore stays high for STOP_BITS×C+1 cycles between back-to-back frames.
- in_valid held continuously: bytes are accepted at the minimum spacing. Each accepted byte is the in_data value present on its accept edge; intermediate counter values are dropped, with no buffering beyond the single frame.
- No X on outputs after reset; tx never glitches within a bit period.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1 → tx=1, in_ready=1, busy=0, frame_done=0, no accept occurs. Release → byte accepted on first edge.
- Single byte, C=4, STOP_BITS=1, PARITY_EN=0, in_data=0xA5 for one cycle:
  - tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - frame_done pulses 40 cycles after the accept edge.
  - in_ready=1 on that cycle.
- Back-to-back from the live counter, in_valid tied 1:
  - Accepts occur every 41 cycles.
  - tx high for exactly 5 cycles between frames.
  - Each frame's data equals the counter value sampled at its accept edge.
- Parity, C=4, PARITY_EN=1:
  - 0x07 → parity bit 1, frame length 44 cycles.
  - 0xFF → parity bit 0.
  - STOP_BITS=2 with 0x07 → stop high 8 cycles, frame length 48 cycles.
- Busy interference: after accepting 0x3C, toggle in_valid and sweep in_data through 0x00..0xFF during the frame → no new accept until IDLE; transmitted bits still encode 0x3C.
- Mid-frame reset: assert reset during data bit 3 of 0x5A → tx=1 in the same cycle, busy=0. After release, send 0x81 → a clean full frame with no remnant of 0x5A.
